// File: rtl/hs_arbiter2.sv
// hs_arbiter2: two-requester round-robin arbiter merging two-phase bundled-data channels onto one.
// Define HS_ARB_SYNC_EN to pass every incoming handshake wire through a two-flop synchronizer.

`ifdef HS_ARB_SYNC_EN
module hs_arb2_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] pipe;

  always_ff @(posedge clock) begin
    if (reset) pipe <= '0;
    else       pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];
endmodule
`endif

// One requester lane: optional req synchronizer, the lane's ack register and its pending flag.
module hs_arb2_port (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic ack_toggle,
  output logic ack,
  output logic pending
);
  logic req_s;

`ifdef HS_ARB_SYNC_EN
  hs_arb2_sync u_sync (.clock(clock), .reset(reset), .d(req), .q(req_s));
`else
  assign req_s = req;
`endif

  always_ff @(posedge clock) begin
    if (reset)           ack <= 1'b0;
    else if (ack_toggle) ack <= ~ack;
  end

  assign pending = req_s ^ ack;
endmodule

module hs_arbiter2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_In0_HS_Req,
  output logic                  io_In0_HS_Ack,
  input  logic [DATA_WIDTH-1:0] io_In0_Data,
  input  logic                  io_In1_HS_Req,
  output logic                  io_In1_HS_Ack,
  input  logic [DATA_WIDTH-1:0] io_In1_Data,
  output logic                  io_Out_HS_Req,
  input  logic                  io_Out_HS_Ack,
  output logic [DATA_WIDTH-1:0] io_Out_Data,
  output logic                  io_Grant,
  output logic                  io_Busy
);
  localparam int NUM_REQ = 2;

  typedef enum logic {IDLE, WAIT_OUT} state_t;

  state_t                               state;
  logic   [NUM_REQ-1:0]                 req, ack, pending, ack_toggle;
  logic   [NUM_REQ-1:0][DATA_WIDTH-1:0] data;
  logic                                 ptr, winner, out_ack_s, out_done;

  assign req  = {io_In1_HS_Req, io_In0_HS_Req};
  assign data = {io_In1_Data, io_In0_Data};

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
    hs_arb2_port u_port (
      .clock      (clock),
      .reset      (reset),
      .req        (req[i]),
      .ack_toggle (ack_toggle[i]),
      .ack        (ack[i]),
      .pending    (pending[i])
    );
  end

`ifdef HS_ARB_SYNC_EN
  hs_arb2_sync u_out_sync (.clock(clock), .reset(reset), .d(io_Out_HS_Ack), .q(out_ack_s));
`else
  assign out_ack_s = io_Out_HS_Ack;
`endif

  assign out_done      = (out_ack_s == io_Out_HS_Req);
  assign io_In0_HS_Ack = ack[0];
  assign io_In1_HS_Ack = ack[1];

  // A lone requester wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    winner = ptr;
    if (pending[1] && !pending[0])      winner = 1'b1;
    else if (pending[0] && !pending[1]) winner = 1'b0;
  end

  // Only the granted lane's ack flips, and only once the shared channel has completed.
  assign ack_toggle = (state == WAIT_OUT && out_done) ? (io_Grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      io_Grant      <= 1'b0;
      io_Busy       <= 1'b0;
      io_Out_HS_Req <= 1'b0;
      io_Out_Data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            io_Out_Data   <= data[winner];
            io_Grant      <= winner;
            ptr           <= ~winner;
            io_Out_HS_Req <= ~io_Out_HS_Req;
            io_Busy       <= 1'b1;
            state         <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          if (out_done) begin
            io_Busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
